// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_pkg
// Description : State, mode and y-select codes shared by the sequencing
//               control path.
// Revision    : 1.0
// ============================================================================
package control_pkg;

    typedef enum logic [3:0] {
        ST_OFF       = 4'd0,
        ST_LIST_WAIT = 4'd1,
        ST_CNT       = 4'd2,
        ST_UP_WAIT   = 4'd3,
        ST_SEQ_LOAD  = 4'd4,
        ST_SEQ_HOLD  = 4'd5,
        ST_SEQ_STEP  = 4'd6,
        ST_UP_STORE  = 4'd7,
        ST_UP_NEXT   = 4'd8,
        ST_UP_DEC    = 4'd9,
        ST_DONE      = 4'd10
    } state_t;

    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_LIST = 2'd1;
    localparam logic [1:0] MODE_CNT  = 2'd2;
    localparam logic [1:0] MODE_UPD  = 2'd3;

    localparam logic [1:0] YSEL_NONE = 2'd0;
    localparam logic [1:0] YSEL_INC  = 2'd1;
    localparam logic [1:0] YSEL_UPD  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : dwell_timer
// Description : Loadable down-counter with a zero flag for LIST dwell timing.
// Revision    : 1.0
// ============================================================================
module dwell_timer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [DWELL_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/control_path_seq.sv
`default_nettype none
// ============================================================================
// Module      : control_path_seq
// Description : Mode FSM sequencing the s/y datapath: LIST countdown with
//               dwell, COUNT, atomic UPDATE, start-edge arming and done pulse.
// Revision    : 1.0
// ============================================================================
module control_path_seq
    import control_pkg::*;
#(
    parameter int STEP_W    = 3,
    parameter int SEQ_START = 6,
    parameter int SEQ_DEC   = 2,
    parameter int SEQ_STEPS = 4,
    parameter int DWELL     = 3,
    parameter int DWELL_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        on,
    input  logic              start,
    input  logic              y_inc,
    output logic [1:0]        regime,
    output logic              active,
    output logic [1:0]        y_select_next,
    output logic [STEP_W-1:0] s_step,
    output logic              y_en,
    output logic              s_en,
    output logic              y_store_x,
    output logic              s_add,
    output logic              s_zero,
    output logic [3:0]        real_state,
    output logic              done
);

    localparam int LEFT_W = (SEQ_STEPS > 1) ? $clog2(SEQ_STEPS) : 1;

    state_t            r_state;
    logic              r_start_q;
    logic [1:0]        r_regime;
    logic [LEFT_W-1:0] r_left;

    logic w_start_rise;
    logic w_list_abort;
    logic w_dwell_load;
    logic w_dwell_dec;
    logic w_dwell_zero;

    assign w_start_rise = start & ~r_start_q;
    assign w_list_abort = ~start | (on != MODE_LIST);
    assign w_dwell_load = (r_state == ST_SEQ_LOAD) || (r_state == ST_SEQ_STEP);
    assign w_dwell_dec  = (r_state == ST_SEQ_HOLD);

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (w_dwell_load),
        .load_val (DWELL_W'(DWELL)),
        .dec      (w_dwell_dec),
        .zero     (w_dwell_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_OFF;
            r_start_q <= 1'b0;
            r_regime  <= MODE_OFF;
            r_left    <= '0;
        end else begin
            r_start_q <= start;
            case (r_state)
                ST_OFF: begin
                    r_regime <= on;
                    case (on)
                        MODE_LIST: r_state <= ST_LIST_WAIT;
                        MODE_CNT:  r_state <= ST_CNT;
                        MODE_UPD:  r_state <= ST_UP_WAIT;
                        default:   r_state <= ST_OFF;
                    endcase
                end
                ST_LIST_WAIT: begin
                    if (on != r_regime)    r_state <= ST_OFF;
                    else if (w_start_rise) r_state <= ST_SEQ_LOAD;
                end
                ST_UP_WAIT: begin
                    if (on != r_regime)    r_state <= ST_OFF;
                    else if (w_start_rise) r_state <= ST_UP_STORE;
                end
                ST_SEQ_LOAD: begin
                    r_left  <= LEFT_W'(SEQ_STEPS - 1);
                    r_state <= w_list_abort ? ST_OFF : ST_SEQ_HOLD;
                end
                // Abort takes priority over dwell expiry.
                ST_SEQ_HOLD: begin
                    if (w_list_abort)      r_state <= ST_OFF;
                    else if (w_dwell_zero) r_state <= (r_left == '0) ? ST_DONE : ST_SEQ_STEP;
                end
                ST_SEQ_STEP: begin
                    r_left  <= r_left - 1'b1;
                    r_state <= w_list_abort ? ST_OFF : ST_SEQ_HOLD;
                end
                ST_CNT: begin
                    if (on != MODE_CNT) r_state <= ST_OFF;
                end
                ST_UP_STORE: r_state <= ST_UP_NEXT;
                ST_UP_NEXT:  r_state <= ST_UP_DEC;
                ST_UP_DEC:   r_state <= ST_DONE;
                ST_DONE:     r_state <= ST_OFF;
                default:     r_state <= ST_OFF;
            endcase
        end
    end

    // Moore decode of the state register; COUNT also follows start/y_inc directly.
    always_comb begin
        active        = 1'b0;
        y_select_next = YSEL_NONE;
        s_step        = '0;
        y_en          = 1'b0;
        s_en          = 1'b0;
        y_store_x     = 1'b0;
        s_add         = 1'b0;
        s_zero        = 1'b0;
        done          = 1'b0;
        case (r_state)
            ST_SEQ_LOAD: begin
                active = 1'b1;
                s_en   = 1'b1;
                s_zero = 1'b1;
                s_add  = 1'b1;
                s_step = STEP_W'(SEQ_START);
            end
            ST_SEQ_HOLD: active = 1'b1;
            ST_SEQ_STEP: begin
                active = 1'b1;
                s_en   = 1'b1;
                s_step = STEP_W'(SEQ_DEC);
            end
            ST_CNT: begin
                s_en          = start;
                s_add         = start;
                s_step        = start ? STEP_W'(1) : '0;
                y_en          = start & y_inc;
                y_select_next = start ? YSEL_INC : YSEL_NONE;
            end
            ST_UP_STORE: begin
                y_en      = 1'b1;
                y_store_x = 1'b1;
            end
            ST_UP_NEXT: begin
                y_en          = 1'b1;
                y_select_next = YSEL_UPD;
            end
            ST_UP_DEC: begin
                s_en   = 1'b1;
                s_step = STEP_W'(1);
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign regime     = (r_state == ST_OFF) ? MODE_OFF : r_regime;
    assign real_state = r_state;

endmodule
`default_nettype wire
